// File: rtl/boron_iter_core_if.sv
// Handshake bundle for the BORON cipher core: block input channel,
// ciphertext output channel and a busy status flag.
interface boron_iter_core_if #(
  parameter int KEY_WIDTH = 128
);
  logic                 in_valid;
  logic                 in_ready;
  logic [63:0]          plain_txt;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          cipher_txt;
  logic                 busy;

  // Producer/consumer side that talks to the core.
  modport master (
    output in_valid,
    output plain_txt,
    output key_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cipher_txt,
    input  busy
  );

  // The cipher core itself.
  modport slave (
    input  in_valid,
    input  plain_txt,
    input  key_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cipher_txt,
    output busy
  );
endinterface

// File: rtl/boron_iter_core.sv
// BORON 64-bit block cipher engine, 25 rounds, 80- or 128-bit key with a
// PRESENT-style key schedule. RPC rounds are cascaded per clock; the
// ciphertext is registered and held until the consumer takes it.
module boron_iter_core #(
  parameter int KEY_WIDTH = 128,
  parameter int RPC       = 1
) (
  input  logic               clk,
  input  logic               reset,
  boron_iter_core_if.slave   bus
);

  // Round counter bit position XORed into the key during the schedule.
  localparam int CNT_LO = (KEY_WIDTH == 128) ? 62 : 15;
  // Value of rnd at the start of the cycle that finishes round 25.
  localparam logic [4:0] LAST_RND = 5'(26 - RPC);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
    $error("boron_iter_core: KEY_WIDTH must be 80 or 128");
  end
  if (!(RPC == 1 || RPC == 5 || RPC == 25)) begin : g_bad_rpc
    $error("boron_iter_core: RPC must be 1, 5 or 25");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t                 fsm_reg;
  logic [63:0]          state_reg;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [4:0]           rnd_reg;
  logic [63:0]          cipher_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 busy_reg;

  // 4-bit BORON substitution box.
  function automatic logic [3:0] boron_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  // Nibble shuffle inside one 16-bit word: (n3 n2 n1 n0) -> (n1 n0 n3 n2).
  function automatic logic [15:0] block_shuffle(input logic [15:0] w);
    return {w[7:4], w[3:0], w[15:12], w[11:8]};
  endfunction

  // Word rotations: word0 <<< 1, word1 <<< 4, word2 <<< 7, word3 <<< 9.
  function automatic logic [63:0] round_p(input logic [63:0] s);
    logic [15:0] w0, w1, w2, w3;
    w0 = s[15:0];
    w1 = s[31:16];
    w2 = s[47:32];
    w3 = s[63:48];
    return {{w3[6:0],  w3[15:7]},
            {w2[8:0],  w2[15:9]},
            {w1[11:0], w1[15:12]},
            {w0[14:0], w0[15]}};
  endfunction

  // Word mixing; the last word folds in the already-updated word 0.
  function automatic logic [63:0] boron_xor(input logic [63:0] s);
    logic [15:0] w0, w1, w2, w3;
    w0 = s[15:0]  ^ s[31:16];
    w1 = s[31:16] ^ s[47:32];
    w2 = s[47:32] ^ s[63:48];
    w3 = s[63:48] ^ w0;
    return {w3, w2, w1, w0};
  endfunction

  // One full data round with round key rk.
  function automatic logic [63:0] boron_round(input logic [63:0] s,
                                              input logic [63:0] rk);
    logic [63:0] x;
    logic [63:0] y;
    x = s ^ rk;
    for (int n = 0; n < 16; n++) begin
      x[4*n +: 4] = boron_sbox(x[4*n +: 4]);
    end
    for (int w = 0; w < 4; w++) begin
      y[16*w +: 16] = block_shuffle(x[16*w +: 16]);
    end
    return boron_xor(round_p(y));
  endfunction

  // Key schedule step for round counter value i.
  function automatic logic [KEY_WIDTH-1:0] key_update(
      input logic [KEY_WIDTH-1:0] k,
      input logic [4:0]           i);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = boron_sbox(r[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) begin
      r[KEY_WIDTH-5 -: 4] = boron_sbox(r[KEY_WIDTH-5 -: 4]);
    end
    r[CNT_LO +: 5] = r[CNT_LO +: 5] ^ i;
    return r;
  endfunction

  // Cascade of RPC rounds evaluated combinationally from the registers.
  logic [63:0]          st_c  [0:RPC];
  logic [KEY_WIDTH-1:0] key_c [0:RPC];

  assign st_c[0]  = state_reg;
  assign key_c[0] = key_reg;

  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    logic [4:0] rnd_idx;
    assign rnd_idx       = rnd_reg + 5'(gi);
    assign st_c[gi + 1]  = boron_round(st_c[gi], key_c[gi][63:0]);
    assign key_c[gi + 1] = key_update(key_c[gi], rnd_idx);
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      key_reg       <= '0;
      rnd_reg       <= '0;
      cipher_reg    <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg    <= bus.plain_txt;
            key_reg      <= bus.key_in;
            rnd_reg      <= 5'd1;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            fsm_reg      <= RUN;
          end
        end
        RUN: begin
          state_reg <= st_c[RPC];
          key_reg   <= key_c[RPC];
          if (rnd_reg == LAST_RND) begin
            // Round 25 done: whiten with K26 and present the result.
            cipher_reg    <= st_c[RPC] ^ key_c[RPC][63:0];
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            rnd_reg       <= '0;
            fsm_reg       <= DONE;
          end else begin
            rnd_reg <= rnd_reg + 5'(RPC);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            fsm_reg       <= IDLE;
          end
        end
        default: begin
          fsm_reg       <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.cipher_txt = cipher_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_boron_iter_core.sv
// Self-checking bench: six cores (80/128-bit key x RPC 1/5/25) share one
// stimulus stream and are checked against a loop-based reference model.
module tb_boron_iter_core;

  localparam int ND = 6;
  localparam int KWS  [ND] = '{128, 128, 128, 80, 80, 80};
  localparam int RPCS [ND] = '{1, 5, 25, 1, 5, 25};
  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                       4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [63:0]   plain_txt = '0;
  logic [127:0]  key128 = '0;
  logic [79:0]   key80 = '0;

  logic [ND-1:0] ov, ir, bz;
  logic [63:0]   ct [ND];

  int            n_cmp = 0;
  int            n_err = 0;
  int            got_lat [ND];
  logic [63:0]   got_ct [ND];
  logic [ND-1:0] acc_busy, acc_ir;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    boron_iter_core_if #(.KEY_WIDTH(KWS[gi])) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.plain_txt = plain_txt;
    assign bus.out_ready = out_ready;
    if (KWS[gi] == 128) begin : g_k128
      assign bus.key_in = key128;
    end else begin : g_k80
      assign bus.key_in = key80;
    end
    assign ov[gi] = bus.out_valid;
    assign ir[gi] = bus.in_ready;
    assign bz[gi] = bus.busy;
    assign ct[gi] = bus.cipher_txt;
    boron_iter_core #(.KEY_WIDTH(KWS[gi]), .RPC(RPCS[gi])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Reference encryption built from the round description using shifts
  // on a 128-bit key value and word arrays.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt,
                                              input logic [127:0] key,
                                              input int kw);
    logic [127:0] k, mask;
    logic [63:0]  s;
    logic [15:0]  w [4];
    logic [31:0]  t;
    int           amt [4];
    amt[0] = 1; amt[1] = 4; amt[2] = 7; amt[3] = 9;
    mask = (kw == 128) ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
    k = key & mask;
    s = pt;
    for (int r = 1; r <= 25; r++) begin
      s = s ^ k[63:0];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      for (int j = 0; j < 4; j++) begin
        t = {16'h0, s[16*j +: 16]};
        t = ((t << 8) | (t >> 8)) & 32'hFFFF;        // byte swap == nibble shuffle
        t = ((t << amt[j]) | (t >> (16 - amt[j]))) & 32'hFFFF;
        w[j] = t[15:0];
      end
      w[0] = w[0] ^ w[1];
      w[1] = w[1] ^ w[2];
      w[2] = w[2] ^ w[3];
      w[3] = w[3] ^ w[0];
      s = {w[3], w[2], w[1], w[0]};
      if (kw == 128) begin
        k = (k << 61) | (k >> 67);
        k[127:124] = SBOX[k[127:124]];
        k[123:120] = SBOX[k[123:120]];
        k = k ^ (128'(r) << 62);
      end else begin
        k = ((k << 61) | (k >> 19)) & mask;
        k[79:76] = SBOX[k[79:76]];
        k = k ^ (128'(r) << 15);
      end
    end
    return s ^ k[63:0];
  endfunction

  function automatic logic [63:0] expect_ct(input int d, input logic [63:0] pt,
                                            input logic [127:0] k128,
                                            input logic [79:0] k80);
    return ref_encrypt(pt, (KWS[d] == 128) ? k128 : {48'h0, k80}, KWS[d]);
  endfunction

  // Issue one block when every core is ready and record per-core latency
  // and first observed ciphertext. Called just after a rising edge.
  task automatic do_block(input logic [63:0] pt, input logic [127:0] k128,
                          input logic [79:0] k80, input logic orr);
    int w;
    w = 0;
    out_ready = orr;
    while (ir !== '1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (ir !== '1) begin
      $display("FAIL ready_wait: in_ready=%b required %b", ir, {ND{1'b1}});
      n_err++;
    end
    plain_txt = pt; key128 = k128; key80 = k80; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_busy = bz;
    acc_ir   = ir;
    for (int d = 0; d < ND; d++) begin
      got_lat[d] = -1;
      got_ct[d]  = '0;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (got_lat[d] < 0 && ov[d] === 1'b1) begin
          got_lat[d] = c;
          got_ct[d]  = ct[d];
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || ct[d] !== 64'h0) begin
          $display("FAIL reset_idle dut%0d cyc%0d: ir=%b ov=%b busy=%b ct=%h required 1 0 0 0",
                   d, c, ir[d], ov[d], bz[d], ct[d]);
          n_err++;
        end
      end
    end
    $display("test_reset: idle checks done");
  endtask

  task automatic check_block(input string tag, input logic [63:0] pt,
                             input logic [127:0] k128, input logic [79:0] k80);
    logic [63:0] exp_ct;
    for (int d = 0; d < ND; d++) begin
      exp_ct = expect_ct(d, pt, k128, k80);
      n_cmp++;
      if (got_ct[d] !== exp_ct) begin
        $display("FAIL %s_ct dut%0d: got %h required %h", tag, d, got_ct[d], exp_ct);
        n_err++;
      end
      n_cmp++;
      if (got_lat[d] !== 25 / RPCS[d]) begin
        $display("FAIL %s_latency dut%0d: got %0d required %0d", tag, d, got_lat[d], 25 / RPCS[d]);
        n_err++;
      end
      n_cmp++;
      if (acc_busy[d] !== 1'b1 || acc_ir[d] !== 1'b0) begin
        $display("FAIL %s_accept dut%0d: busy=%b in_ready=%b required 1 0", tag, d, acc_busy[d], acc_ir[d]);
        n_err++;
      end
      $display("%s dut%0d kw=%0d rpc=%0d pt=%h ct=%h lat=%0d", tag, d, KWS[d], RPCS[d], pt, got_ct[d], got_lat[d]);
    end
  endtask

  task automatic test_vectors;
    do_block(64'h0, 128'h0, 80'h0, 1'b1);
    check_block("vec_zero", 64'h0, 128'h0, 80'h0);
    do_block(64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, {80{1'b1}}, 1'b1);
    check_block("vec_ones", 64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, {80{1'b1}});
    do_block(64'h0123_4567_89AB_CDEF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
             80'h0123_4567_8901_2345_6789, 1'b1);
    check_block("vec_count", 64'h0123_4567_89AB_CDEF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                80'h0123_4567_8901_2345_6789);
  endtask

  task automatic test_random;
    logic [63:0]  pt;
    logic [127:0] k128;
    logic [79:0]  k80;
    for (int t = 0; t < 6; t++) begin
      pt   = {$urandom, $urandom};
      k128 = {$urandom, $urandom, $urandom, $urandom};
      k80  = {16'($urandom), $urandom, $urandom};
      do_block(pt, k128, k80, 1'b1);
      check_block("rand", pt, k128, k80);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] pt;
    logic [127:0] k128;
    logic [79:0] k80;
    pt = {$urandom, $urandom}; k128 = {$urandom, $urandom, $urandom, $urandom};
    k80 = {16'($urandom), $urandom, $urandom};
    do_block(pt, k128, k80, 1'b0);
    check_block("bp", pt, k128, k80);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (ct[d] !== got_ct[d] || ov[d] !== 1'b1 || ir[d] !== 1'b0) begin
          $display("FAIL bp_hold dut%0d cyc%0d: ct=%h ov=%b ir=%b required %h 1 0",
                   d, c, ct[d], ov[d], ir[d], got_ct[d]);
          n_err++;
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
        $display("FAIL bp_release dut%0d: ov=%b ir=%b required 0 1", d, ov[d], ir[d]);
        n_err++;
      end
    end
    $display("test_backpressure: hold and release checked");
  endtask

  task automatic test_busy_input;
    logic [63:0]  pt;
    logic [127:0] k128;
    logic [79:0]  k80;
    logic [63:0]  exp_ct;
    pt = {$urandom, $urandom}; k128 = {$urandom, $urandom, $urandom, $urandom};
    k80 = {16'($urandom), $urandom, $urandom};
    out_ready = 1'b0;
    plain_txt = pt; key128 = k128; key80 = k80; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      got_lat[d] = -1;
      got_ct[d]  = '0;
    end
    for (int c = 1; c <= 35; c++) begin
      plain_txt = {$urandom, $urandom};
      key128    = {$urandom, $urandom, $urandom, $urandom};
      key80     = {16'($urandom), $urandom, $urandom};
      in_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (got_lat[d] < 0 && ov[d] === 1'b1) begin
          got_lat[d] = c;
          got_ct[d]  = ct[d];
        end
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      exp_ct = expect_ct(d, pt, k128, k80);
      n_cmp++;
      if (got_ct[d] !== exp_ct || ct[d] !== exp_ct || got_lat[d] !== 25 / RPCS[d]) begin
        $display("FAIL busy_in dut%0d: first=%h now=%h lat=%0d required %h lat=%0d",
                 d, got_ct[d], ct[d], got_lat[d], exp_ct, 25 / RPCS[d]);
        n_err++;
      end
      n_cmp++;
      if (ir[d] !== 1'b0 || ov[d] !== 1'b1) begin
        $display("FAIL busy_in_hs dut%0d: ir=%b ov=%b required 0 1", d, ir[d], ov[d]);
        n_err++;
      end
      $display("busy_in dut%0d ct=%h lat=%0d", d, got_ct[d], got_lat[d]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    pt = {$urandom, $urandom}; k128 = {$urandom, $urandom, $urandom, $urandom};
    k80 = {16'($urandom), $urandom, $urandom};
    do_block(pt, k128, k80, 1'b1);
    check_block("after_busy", pt, k128, k80);
  endtask

  task automatic test_reset_mid_run;
    logic [63:0]  pt;
    logic [127:0] k128;
    logic [79:0]  k80;
    out_ready = 1'b0;
    plain_txt = {$urandom, $urandom};
    key128 = {$urandom, $urandom, $urandom, $urandom};
    key80 = {16'($urandom), $urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || ct[d] !== 64'h0) begin
        $display("FAIL mid_reset dut%0d: ir=%b ov=%b busy=%b ct=%h required 1 0 0 0",
                 d, ir[d], ov[d], bz[d], ct[d]);
        n_err++;
      end
    end
    pt = {$urandom, $urandom}; k128 = {$urandom, $urandom, $urandom, $urandom};
    k80 = {16'($urandom), $urandom, $urandom};
    do_block(pt, k128, k80, 1'b1);
    check_block("post_reset", pt, k128, k80);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_busy_input();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
